pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// In-order pipeline register chain with global freeze, load-use bubble insertion,
// redirect flush (deferred across a freeze) and retire/bubble counters.
module pipeline_ctrl #(
    parameter int NSTAGES     = 4,
    parameter int W           = 32,
    parameter int HZ_STAGE    = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    input  logic                 mem_wait,
    input  logic                 hazard_stall,
    input  logic                 redirect,
    output logic [NSTAGES-1:0]   stage_valid,
    output logic [NSTAGES*W-1:0] stage_data,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [31:0]          retire_count,
    output logic [31:0]          bubble_count
);

    logic [NSTAGES-1:0] valid_reg, valid_next;
    logic [W-1:0]       data_reg  [NSTAGES];
    logic [W-1:0]       data_next [NSTAGES];
    logic               flush_pending_reg, flush_pending_next;
    logic [31:0]        retire_count_reg, retire_count_next;
    logic [31:0]        bubble_count_reg, bubble_count_next;

    logic flush_now;
    logic stall_now;
    logic accept;

    // A flush outranks a hazard stall; both are meaningless while frozen.
    assign flush_now = !mem_wait && (redirect || flush_pending_reg);
    assign stall_now = !mem_wait && !flush_now && hazard_stall;
    assign in_ready  = !mem_wait && !hazard_stall && !redirect && !flush_pending_reg;
    assign accept    = in_valid && in_ready;

    always_comb begin
        valid_next         = valid_reg;
        flush_pending_next = flush_pending_reg;
        retire_count_next  = retire_count_reg;
        bubble_count_next  = bubble_count_reg;
        for (int i = 0; i < NSTAGES; i++) begin
            data_next[i] = data_reg[i];
        end

        if (mem_wait) begin
            // Remember a redirect seen during the freeze so it fires exactly once later.
            flush_pending_next = flush_pending_reg || redirect;
        end else begin
            flush_pending_next = 1'b0;
            if (valid_reg[NSTAGES-1]) begin
                retire_count_next = retire_count_reg + 32'd1;
            end
            if (flush_now || stall_now) begin
                bubble_count_next = bubble_count_reg + 32'd1;
            end

            valid_next[0] = accept;
            data_next[0]  = accept ? in_data : '0;
            for (int i = 1; i < NSTAGES; i++) begin
                valid_next[i] = valid_reg[i-1];
                data_next[i]  = data_reg[i-1];
            end

            if (flush_now) begin
                for (int i = 0; i < FLUSH_DEPTH; i++) begin
                    valid_next[i] = 1'b0;
                    data_next[i]  = '0;
                end
            end else if (stall_now) begin
                for (int i = 0; i < HZ_STAGE; i++) begin
                    valid_next[i] = valid_reg[i];
                    data_next[i]  = data_reg[i];
                end
                valid_next[HZ_STAGE] = 1'b0;
                data_next[HZ_STAGE]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg         <= '0;
            flush_pending_reg <= 1'b0;
            retire_count_reg  <= '0;
            bubble_count_reg  <= '0;
            for (int i = 0; i < NSTAGES; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg         <= valid_next;
            flush_pending_reg <= flush_pending_next;
            retire_count_reg  <= retire_count_next;
            bubble_count_reg  <= bubble_count_next;
            for (int i = 0; i < NSTAGES; i++) begin
                data_reg[i] <= data_next[i];
            end
        end
    end

    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage_out
        assign stage_data[gi*W +: W] = data_reg[gi];
    end

    assign stage_valid  = valid_reg;
    assign out_valid    = valid_reg[NSTAGES-1];
    assign out_data     = data_reg[NSTAGES-1];
    assign retire_count = retire_count_reg;
    assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected retirements are queued at issue time and
// checked by an independent monitor; stage contents are checked inline.
module tb_pipeline_ctrl;
    localparam int NS = 4;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          mem_wait;
    logic          hazard_stall;
    logic          redirect;
    logic [NS-1:0] stage_valid;
    logic [NS*W-1:0] stage_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [31:0]   retire_count;
    logic [31:0]   bubble_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [$];

    pipeline_ctrl #(.NSTAGES(NS), .W(W), .HZ_STAGE(1), .FLUSH_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wait(mem_wait), .hazard_stall(hazard_stall), .redirect(redirect),
        .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
        .out_data(out_data), .retire_count(retire_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] sd(input int i);
        return stage_data[i*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [W-1:0] d, input bit will_retire);
        in_valid = 1'b1;
        in_data  = d;
        if (will_retire) exp_q.push_back(d);
        step();
    endtask

    // Monitor: anything in the last stage with no freeze retires at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && mem_wait === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL retire_order: got %0h, required no retirement", out_data);
                end else begin
                    check("retire_order", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        mem_wait = 1'b0; hazard_stall = 1'b0; redirect = 1'b0;
        #2;
        check("reset_valid", stage_valid, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_retire", retire_count, 0);
        check("reset_bubble", bubble_count, 0);
        step(); step();
        @(negedge clk);
        rst = 1'b0;

        // Streaming 1..8
        for (int k = 1; k <= 8; k++) begin
            feed(W'(k), 1'b1);
            if (k == 3) check("latency_not_yet", out_valid, 0);
            if (k == 4) begin
                check("latency_out_valid", out_valid, 1);
                check("latency_out_data", out_data, 1);
            end
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("stream_retire", retire_count, 8);

        // Load-use bubble
        feed(4, 1'b1);
        feed(5, 1'b1);
        in_valid = 1'b1; in_data = 99; hazard_stall = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 0);
        step();
        hazard_stall = 1'b0; in_valid = 1'b0;
        check("stall_s0_valid", stage_valid[0], 1);
        check("stall_s0_data", sd(0), 5);
        check("stall_s1_valid", stage_valid[1], 0);
        check("stall_s1_data", sd(1), 0);
        check("stall_s2_data", sd(2), 4);
        check("stall_bubble", bubble_count, 1);
        repeat (5) step();
        check("stall_retire", retire_count, 10);

        // Redirect with 7,6,5,4 in stages 0..3
        feed(4, 1'b1); feed(5, 1'b1); feed(6, 1'b1); feed(7, 1'b0);
        in_valid = 1'b1; in_data = 8; redirect = 1'b1;
        #1;
        check("redirect_in_ready", in_ready, 0);
        step();
        redirect = 1'b0; in_valid = 1'b0;
        check("redirect_valid", stage_valid, 4'b1100);
        check("redirect_s0_data", sd(0), 0);
        check("redirect_s2_data", sd(2), 6);
        check("redirect_s3_data", sd(3), 5);
        check("redirect_bubble", bubble_count, 2);
        repeat (3) step();
        check("redirect_retire", retire_count, 13);

        // Redirect during a 3-cycle freeze
        feed(21, 1'b1); feed(22, 1'b1); feed(23, 1'b1); feed(24, 1'b0);
        mem_wait = 1'b1; redirect = 1'b1; in_valid = 1'b1; in_data = 99;
        #1;
        check("freeze_in_ready", in_ready, 0);
        step();
        redirect = 1'b0;
        step(); step();
        in_valid = 1'b0;
        check("freeze_valid", stage_valid, 4'b1111);
        check("freeze_s0_data", sd(0), 24);
        check("freeze_s3_data", sd(3), 21);
        check("freeze_retire", retire_count, 13);
        check("freeze_bubble", bubble_count, 2);
        mem_wait = 1'b0; in_valid = 1'b1; in_data = 99;
        #1;
        check("pending_in_ready", in_ready, 0);
        step();
        check("pending_flush_valid", stage_valid, 4'b1100);
        check("pending_flush_s3", sd(3), 22);
        check("pending_flush_bubble", bubble_count, 3);
        in_data = 30;
        #1;
        check("pending_cleared_ready", in_ready, 1);
        feed(30, 1'b1);
        in_valid = 1'b0;
        check("flush_once_valid", stage_valid, 4'b1001);
        check("flush_once_bubble", bubble_count, 3);
        repeat (4) step();
        check("freeze_total_retire", retire_count, 17);

        // Redirect and hazard together
        feed(41, 1'b1); feed(42, 1'b1); feed(43, 1'b1); feed(44, 1'b0);
        in_valid = 1'b0; redirect = 1'b1; hazard_stall = 1'b1;
        step();
        redirect = 1'b0; hazard_stall = 1'b0;
        check("both_valid", stage_valid, 4'b1100);
        check("both_s0_data", sd(0), 0);
        check("both_s2_data", sd(2), 43);
        check("both_bubble", bubble_count, 4);
        repeat (3) step();
        check("both_retire", retire_count, 20);

        // Asynchronous reset while a flush is pending
        feed(51, 1'b0); feed(52, 1'b0);
        in_valid = 1'b0; mem_wait = 1'b1; redirect = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", stage_valid, 0);
        check("async_rst_data", stage_data, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_retire", retire_count, 0);
        check("async_rst_bubble", bubble_count, 0);
        @(negedge clk);
        rst = 1'b0; mem_wait = 1'b0; redirect = 1'b0; in_valid = 1'b1; in_data = 60;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        feed(60, 1'b1);
        in_valid = 1'b0;
        check("post_rst_valid", stage_valid, 4'b0001);
        check("post_rst_s0", sd(0), 60);
        check("post_rst_bubble", bubble_count, 0);
        repeat (4) step();
        check("post_rst_retire", retire_count, 1);

        // Retire counter wrap
        feed(70, 1'b1);
        in_valid = 1'b0;
        repeat (3) step();
        check("wrap_out_valid", out_valid, 1);
        @(negedge clk);
        dut.retire_count_reg <= 32'hFFFF_FFFF;
        step();
        check("wrap_retire", retire_count, 0);

        repeat (2) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
